mv_pair_fifo: RTL

Parametrised buffer for motion-vector pairs between the MV generator and the fractional interpolation datapath. It stores up to DEPTH signed (X, Y) motion vectors and presents the oldest entry at its outputs (first-word fall-through). It optionally saturates each component on write and reports occupancy, full/empty status and sticky overflow/underflow errors. It replaces the single-entry per-component MV registers.

---
 rtl/mv_pair_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mv_pair_fifo.sv
// Motion-vector pair FIFO between the MV generator and the fractional interpolation datapath.
// Latency: a push is visible at the first-word fall-through head one cycle later; a pop advances the head on the same edge.
// Backpressure: FULL/EMPTY are status only. A push while full is dropped and sets OVERFLOW. A pop while empty is ignored and sets UNDERFLOW.
//
// Ports:
//   CLK, RST_ASYNC_N        clock (rising edge); asynchronous active-low reset
//   FLUSH                   synchronous clear of pointers, count and error flags
//   PUSH, MV_X_IN, MV_Y_IN  write one signed (X, Y) pair, optionally saturated
//   POP                     discard the head entry
//   MV_X_OUT, MV_Y_OUT      head entry; forced to 0 while EMPTY
//   EMPTY, FULL, COUNT      occupancy status, all derived from the count register
//   OVERFLOW, UNDERFLOW     sticky error flags, cleared by FLUSH or reset
module mv_pair_fifo #(
  parameter int MV_WIDTH = 19,
  parameter int DEPTH    = 4,
  parameter int SAT_EN   = 0,
  parameter int MV_LIMIT = 2**(MV_WIDTH-1)-1
) (
  input  logic                              CLK,
  input  logic                              RST_ASYNC_N,
  input  logic                              FLUSH,
  input  logic                              PUSH,
  input  logic signed [MV_WIDTH-1:0]        MV_X_IN,
  input  logic signed [MV_WIDTH-1:0]        MV_Y_IN,
  input  logic                              POP,
  output logic signed [MV_WIDTH-1:0]        MV_X_OUT,
  output logic signed [MV_WIDTH-1:0]        MV_Y_OUT,
  output logic                              EMPTY,
  output logic                              FULL,
  output logic        [$clog2(DEPTH):0]     COUNT,
  output logic                              OVERFLOW,
  output logic                              UNDERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic signed [MV_WIDTH-1:0] mv_t;

  typedef struct packed {
    mv_t x;
    mv_t y;
  } pair_t;

  localparam mv_t LIM_POS = mv_t'(MV_LIMIT);
  localparam mv_t LIM_NEG = mv_t'(-MV_LIMIT);

  // Clamp is a signed compare at full component width, so negative inputs
  // can never be mistaken for large positive ones.
  function automatic mv_t clamp(input mv_t v);
    mv_t r;
    r = v;
    if (SAT_EN != 0) begin
      if (v > LIM_POS) begin
        r = LIM_POS;
      end else if (v < LIM_NEG) begin
        r = LIM_NEG;
      end
    end
    return r;
  endfunction

  pair_t          mem_q [DEPTH];
  pair_t          mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic           empty;
  logic           full;
  logic           push_ok;
  logic           pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A full FIFO is never empty, so a pop in the same cycle always frees the
  // slot the push is about to take.
  assign pop_ok  = POP && !empty;
  assign push_ok = PUSH && (!full || POP);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (FLUSH) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = '{x: clamp(MV_X_IN), y: clamp(MV_Y_IN)};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (PUSH && full && !POP) begin
        overflow_d = 1'b1;
      end
      if (POP && empty) begin
        underflow_d = 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Head comes straight from registers; stale slots are masked while empty.
  assign MV_X_OUT  = empty ? '0 : mem_q[rd_ptr_q].x;
  assign MV_Y_OUT  = empty ? '0 : mem_q[rd_ptr_q].y;
  assign EMPTY     = empty;
  assign FULL      = full;
  assign COUNT     = count_q;
  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;

endmodule
